// File: rtl/framestore_arbiter.sv
// Three-port arbiter for the framestore word port: registered grant, one
// transaction in flight, memory ack steered back to the granted requester.
package framestore_arbiter_pkg;
  localparam int NUM_PORTS = 3;
  localparam int ADDR_W    = 18;
  localparam int DATA_W    = 32;
  localparam int BE_W      = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   nbyte;
    logic              rnw;
    logic [DATA_W-1:0] w_data;
  } fs_req_t;

  localparam fs_req_t FS_REQ_RST = '{address: '0, nbyte: '1, rnw: 1'b1, w_data: '0};
endpackage

// One requester slot: bundles its parameters and decodes its own ack.
module framestore_arbiter_port
  import framestore_arbiter_pkg::*;
#(
  parameter logic [1:0] IDX = 2'd0
) (
  input  logic              req,
  input  logic [ADDR_W-1:0] address,
  input  logic [BE_W-1:0]   nbyte,
  input  logic              rnw,
  input  logic [DATA_W-1:0] w_data,
  input  logic              mem_ack,
  input  logic              busy,
  input  logic [1:0]        grant,
  output logic              valid,
  output fs_req_t           pkt,
  output logic              ack
);
  assign valid = req;
  assign pkt   = '{address: address, nbyte: nbyte, rnw: rnw, w_data: w_data};
  // Memory ack only counts while a transaction is actually outstanding.
  assign ack   = mem_ack & busy & (grant == IDX);
endmodule

module framestore_arbiter
  import framestore_arbiter_pkg::*;
#(
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              p0_req,
  output logic              p0_ack,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [BE_W-1:0]   p0_nbyte,
  input  logic              p0_rnw,
  input  logic [DATA_W-1:0] p0_w_data,
  output logic [DATA_W-1:0] p0_r_data,

  input  logic              p1_req,
  output logic              p1_ack,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [BE_W-1:0]   p1_nbyte,
  input  logic              p1_rnw,
  input  logic [DATA_W-1:0] p1_w_data,
  output logic [DATA_W-1:0] p1_r_data,

  input  logic              p2_req,
  output logic              p2_ack,
  input  logic [ADDR_W-1:0] p2_address,
  input  logic [BE_W-1:0]   p2_nbyte,
  input  logic              p2_rnw,
  input  logic [DATA_W-1:0] p2_w_data,
  output logic [DATA_W-1:0] p2_r_data,

  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_nbyte,
  output logic              mem_rnw,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data,

  output logic [1:0]        grant
);
  typedef enum logic [1:0] {IDLE, BUSY, DATA} state_t;

  state_t  state;
  fs_req_t mem_q;
  logic [1:0] rr_ptr;

  logic [NUM_PORTS-1:0]              req_vec;
  logic [NUM_PORTS-1:0]              ack_vec;
  fs_req_t [NUM_PORTS-1:0]           pkt;
  logic [NUM_PORTS-1:0]              p_req_a, p_rnw_a;
  logic [NUM_PORTS-1:0][ADDR_W-1:0]  p_addr_a;
  logic [NUM_PORTS-1:0][BE_W-1:0]    p_nbyte_a;
  logic [NUM_PORTS-1:0][DATA_W-1:0]  p_wdata_a;

  assign p_req_a   = {p2_req, p1_req, p0_req};
  assign p_rnw_a   = {p2_rnw, p1_rnw, p0_rnw};
  assign p_addr_a  = {p2_address, p1_address, p0_address};
  assign p_nbyte_a = {p2_nbyte, p1_nbyte, p0_nbyte};
  assign p_wdata_a = {p2_w_data, p1_w_data, p0_w_data};

  for (genvar n = 0; n < NUM_PORTS; n++) begin : g_port
    framestore_arbiter_port #(.IDX(2'(n))) u_port (
      .req     (p_req_a[n]),
      .address (p_addr_a[n]),
      .nbyte   (p_nbyte_a[n]),
      .rnw     (p_rnw_a[n]),
      .w_data  (p_wdata_a[n]),
      .mem_ack (mem_ack),
      .busy    (state == BUSY),
      .grant   (grant),
      .valid   (req_vec[n]),
      .pkt     (pkt[n]),
      .ack     (ack_vec[n])
    );
  end

  assign p0_ack = ack_vec[0];
  assign p1_ack = ack_vec[1];
  assign p2_ack = ack_vec[2];

  assign p0_r_data = mem_r_data;
  assign p1_r_data = mem_r_data;
  assign p2_r_data = mem_r_data;

  assign mem_address = mem_q.address;
  assign mem_nbyte   = mem_q.nbyte;
  assign mem_rnw     = mem_q.rnw;
  assign mem_w_data  = mem_q.w_data;

  function automatic logic [1:0] wrap_inc(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Fixed priority is the round-robin search with its start pinned at port 0.
  logic [1:0] win, cand;
  logic       found;
  always_comb begin
    win   = 2'd0;
    found = 1'b0;
    cand  = (FIXED_PRI != 0) ? 2'd0 : wrap_inc(rr_ptr);
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req_vec[cand]) begin
        win   = cand;
        found = 1'b1;
      end
      cand = wrap_inc(cand);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      mem_q   <= FS_REQ_RST;
      grant   <= 2'd0;
      rr_ptr  <= 2'd2;
    end else begin
      case (state)
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= DATA;
          end
        end
        default: begin
          // New grants only from IDLE/DATA, so a req still high on its ack edge is never re-taken.
          if (found) begin
            mem_q   <= pkt[win];
            grant   <= win;
            rr_ptr  <= win;
            mem_req <= 1'b1;
            state   <= BUSY;
          end else begin
            state   <= IDLE;
          end
        end
      endcase
    end
  end
endmodule
